// File: rtl/switch_debounce_pkg.sv
// Shared constants for the slide-switch debouncer feeding the fraction encoder.
package switch_debounce_pkg;

  localparam int unsigned SW_WIDTH             = 10;
  localparam int unsigned CLK_HZ               = 50_000_000;
  localparam int unsigned DEFAULT_TICK_DIV     = CLK_HZ / 1000;
  localparam int unsigned DEFAULT_STABLE_TICKS = 20;
  localparam logic [SW_WIDTH-1:0] SW_RESET_VAL = '0;

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-flop synchronizer, stability counter and registered edge pulses.
module debounce_bit
  import switch_debounce_pkg::*;
#(
  parameter int unsigned STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic        RESET_VAL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_sw,
  output logic o_db,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CW = $clog2(STABLE_TICKS + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_db;
  logic          r_rise;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= RESET_VAL;
      r_sync2 <= RESET_VAL;
      r_db    <= RESET_VAL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_sw;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any return to the accepted level restarts qualification, tick or not.
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (i_tick && (r_cnt == CW'(STABLE_TICKS - 1))) begin
        r_db   <= r_sync2;
        r_cnt  <= '0;
        r_rise <= r_sync2;
        r_fall <= ~r_sync2;
      end else if (i_tick) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_db   = r_db;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/switch_debounce.sv
// Debounces the raw slide switches; one shared sample-tick prescaler drives all bits.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int unsigned         WIDTH        = SW_WIDTH,
  parameter int unsigned         TICK_DIV     = DEFAULT_TICK_DIV,
  parameter int unsigned         STABLE_TICKS = DEFAULT_STABLE_TICKS,
  parameter logic [WIDTH-1:0]    RESET_VAL    = SW_RESET_VAL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] switches,
  output logic [WIDTH-1:0] switches_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [TW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == TW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + TW'(1);
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS),
      .RESET_VAL   (RESET_VAL[g])
    ) u_bit (
      .clk   (clk),
      .rst   (rst),
      .i_tick(w_tick),
      .i_sw  (switches[g]),
      .o_db  (switches_db[g]),
      .o_rise(sw_rise[g]),
      .o_fall(sw_fall[g])
    );
  end

endmodule

// File: doc/switch_debounce.md
# switch_debounce

Synchronizes and debounces the ten raw slide-switch inputs before they reach the switch-to-ASCII fraction encoder. It sits directly upstream of that encoder and drives the encoder's `switches` bus with clean, glitch-free levels. It also provides one-cycle rise/fall pulses per switch for edge-driven consumers. A shared prescaler sets the sampling rate, and each bit keeps its own stability counter.

## Interface
- `WIDTH`, 10: number of switch bits.
- `TICK_DIV`, 50000: clk cycles per sample tick (1 ms at 50 MHz); must be ≥1.
- `STABLE_TICKS`, 20: consecutive ticks a changed level must hold before it is accepted; must be ≥1.
- `RESET_VAL`, 0: `WIDTH`-bit value loaded into the synchronizer and into `switches_db` on reset.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `switches`  in  WIDTH  raw asynchronous switch levels.
- `switches_db`  out  WIDTH  debounced levels; feeds the fraction encoder.
- `sw_rise`  out  WIDTH  one-cycle pulse when `switches_db[i]` goes 0→1.
- `sw_fall`  out  WIDTH  one-cycle pulse when `switches_db[i]` goes 1→0.

## Operation
- Synchronizer: each bit passes through two flops, giving `sync[i]`. Both stages reset to `RESET_VAL[i]`.
- Prescaler: a counter runs 0..`TICK_DIV`-1 and wraps to 0.
  - `tick` is high for one cycle when the count equals `TICK_DIV`-1.
  - With `TICK_DIV`=1, `tick` is high every cycle.
  - Counter width is `$clog2(TICK_DIV)` (minimum 1).
- Per-bit counter `cnt[i]`, width `$clog2(STABLE_TICKS+1)`. Evaluated every clk cycle, in priority order:
  1. `sync[i]==switches_db[i]`: `cnt[i]`←0, independent of `tick`. Any bounce back restarts qualification.
  2. Else if `tick` and `cnt[i]==STABLE_TICKS-1`: `switches_db[i]`←`sync[i]`, `cnt[i]`←0, and the matching edge pulse is asserted.
  3. Else if `tick`: `cnt[i]`←`cnt[i]`+1.
  4. Else: hold.
- Edge pulses: `sw_rise[i]`/`sw_fall[i]` are registered. Each goes high on the same clk edge that updates `switches_db[i]` and stays high for exactly one cycle. Rise and fall are never high together.
- Bits are independent. Simultaneous qualifying changes on several bits update in the same cycle.
- Glitches are rejected when they either:
  - resolve before the next tick, or
  - revert at any point before the `STABLE_TICKS`-th tick.
- Reset (asserted at any time, including mid-count):
  - Takes effect immediately.
  - Clears the prescaler and all `cnt[i]`.
  - Sets `switches_db`=`RESET_VAL` and `sw_rise`=`sw_fall`=0.
  - After release, qualification starts from zero. No pulses are emitted until a bit genuinely qualifies.

## Timing
- Reset values: `switches_db`=`RESET_VAL`, `sw_rise`=0, `sw_fall`=0.
- Latency from a clean input step to the `switches_db` update:
  - 2 synchronizer cycles, plus
  - between (`STABLE_TICKS`-1)·`TICK_DIV`+1 and `STABLE_TICKS`·`TICK_DIV` cycles, depending on prescaler phase.
- With `TICK_DIV`=4 and `STABLE_TICKS`=3, the update occurs 11–14 cycles after the input edge.
- Outputs are fully registered, with no combinational path from `switches` to any output.

## Structure
- Package `switch_debounce_pkg` holds:
  - `SW_WIDTH`=10,
  - `CLK_HZ`=50_000_000,
  - `DEFAULT_TICK_DIV`,
  - `DEFAULT_STABLE_TICKS`,
  - `SW_RESET_VAL`.
- Sub-module `debounce_bit` contains one synchronizer, one counter and one edge-pulse pair. It takes `tick` as an input and is instantiated `WIDTH` times via generate.
- The prescaler lives in the top level and is shared by all bits.

## Test plan
Bench parameters: `TICK_DIV`=4, `STABLE_TICKS`=3, `RESET_VAL`=0.
- Reset: hold `rst`=1 with `switches`=10'h3FF.
  - During reset: `switches_db`=0, all pulses 0.
  - After release: `switches_db`=10'h3FF within 11–14 cycles, `sw_rise`=10'h3FF for exactly one cycle.
- Bounce: toggle `switches[2]` every 3 cycles for 30 cycles, then hold 1.
  - `switches_db[2]` stays 0 throughout the bounce.
  - `switches_db[2]` goes to 1 within 14 cycles of the final edge, with exactly one `sw_rise[2]` pulse.
- Glitch: 1-cycle high pulse on `switches[0]`.
  - `switches_db[0]` stays 0, no pulses.
- Fall: from `switches_db[5]`=1, drive `switches[5]`=0.
  - `sw_fall[5]` high for one cycle and `switches_db[5]`=0, both within 11–14 cycles.
- Simultaneous: `switches[1]` and `switches[4]` go 0→1 in the same cycle.
  - Both `switches_db` bits update on the same edge, with `sw_rise`=10'h012 for one cycle.
- Reset mid-count: drive `switches[3]`=1, wait 2 ticks, pulse `rst` for 1 cycle.
  - `switches_db[3]` stays 0 through the reset.
  - Qualification restarts after release; `sw_rise[3]` occurs 11–14 cycles after release.
